// File: rtl/wb_pkg.sv
// Shared types for the Wishbone address decoder: FSM states and response
// encoding, plus the helper that applies slave response priority.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_ACK  = 2'd1,
        RSP_ERR  = 2'd2,
        RSP_RTY  = 2'd3
    } rsp_t;

    // Collapse simultaneous slave responses to one: err beats rty beats ack.
    function automatic rsp_t rsp_select(input logic ack, input logic err, input logic rty);
        rsp_t rsp;
        rsp = RSP_NONE;
        if (err) begin
            rsp = RSP_ERR;
        end else if (rty) begin
            rsp = RSP_RTY;
        end else if (ack) begin
            rsp = RSP_ACK;
        end
        return rsp;
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// One-hot priority encoder: keeps only the highest-priority set request bit.
// LSB_HIGH_PRIORITY selects whether bit 0 or bit WIDTH-1 wins.
module priority_encoder #(
    parameter int unsigned WIDTH             = 4,
    parameter bit          LSB_HIGH_PRIORITY = 1'b1
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] onehot_c,
    output logic             valid_c
);

    // Later loop iterations overwrite earlier ones, so scan towards the winner.
    always_comb begin
        onehot_c = '0;
        valid_c  = 1'b0;
        if (LSB_HIGH_PRIORITY) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    onehot_c    = '0;
                    onehot_c[i] = 1'b1;
                    valid_c     = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (req[i]) begin
                    onehot_c    = '0;
                    onehot_c[i] = 1'b1;
                    valid_c     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_decoder.sv
// Wishbone classic 1-to-N address decoder with one outstanding access,
// registered request/response paths and a BUSY-state timeout.
module wb_decoder
    import wb_pkg::*;
#(
    parameter int unsigned                   PORTS      = 4,
    parameter int unsigned                   ADDR_WIDTH = 32,
    parameter int unsigned                   DATA_WIDTH = 32,
    parameter logic [PORTS*ADDR_WIDTH-1:0]   SLAVE_BASE = {32'h3000_0000, 32'h2000_0000,
                                                           32'h1000_0000, 32'h0000_0000},
    parameter logic [PORTS*ADDR_WIDTH-1:0]   SLAVE_MASK = {PORTS{32'hF000_0000}},
    parameter int unsigned                   TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic [ADDR_WIDTH-1:0]         wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]         wbm_dat_i,
    input  logic [DATA_WIDTH/8-1:0]       wbm_sel_i,
    input  logic                          wbm_we_i,
    input  logic                          wbm_stb_i,
    input  logic                          wbm_cyc_i,
    output logic [DATA_WIDTH-1:0]         wbm_dat_o,
    output logic                          wbm_ack_o,
    output logic                          wbm_err_o,
    output logic                          wbm_rty_o,

    output logic [ADDR_WIDTH-1:0]         wbs_adr_o,
    output logic [DATA_WIDTH-1:0]         wbs_dat_o,
    output logic [DATA_WIDTH/8-1:0]       wbs_sel_o,
    output logic                          wbs_we_o,
    output logic [PORTS-1:0]              wbs_cyc_o,
    output logic [PORTS-1:0]              wbs_stb_o,
    input  logic [PORTS*DATA_WIDTH-1:0]   wbs_dat_i,
    input  logic [PORTS-1:0]              wbs_ack_i,
    input  logic [PORTS-1:0]              wbs_err_i,
    input  logic [PORTS-1:0]              wbs_rty_i
);

    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TO_LAST   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TO_LAST);

    state_t                 state;
    logic [PORTS-1:0]       sel_q;
    logic [CNT_WIDTH-1:0]   cnt;

    logic [PORTS-1:0]       match_c;
    logic [PORTS-1:0]       hit_onehot_c;
    logic                   hit_c;
    logic                   sel_ack_c;
    logic                   sel_err_c;
    logic                   sel_rty_c;
    rsp_t                   rsp_c;
    logic [DATA_WIDTH-1:0]  rd_data_c;

    // Per-port masked base compare on the live master address.
    always_comb begin
        match_c = '0;
        for (int i = 0; i < PORTS; i++) begin
            match_c[i] = ((wbm_adr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                          (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] &
                           SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]));
        end
    end

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (1'b1)
    ) u_match_pe (
        .req      (match_c),
        .onehot_c (hit_onehot_c),
        .valid_c  (hit_c)
    );

    // Only the latched slave may respond; others are masked out here.
    always_comb begin
        sel_ack_c = |(sel_q & wbs_ack_i);
        sel_err_c = |(sel_q & wbs_err_i);
        sel_rty_c = |(sel_q & wbs_rty_i);
        rsp_c     = rsp_select(sel_ack_c, sel_err_c, sel_rty_c);
    end

    // Read data mux driven by the one-hot select.
    always_comb begin
        rd_data_c = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (sel_q[i]) begin
                rd_data_c = rd_data_c | wbs_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sel_q     <= '0;
            cnt       <= '0;
            wbm_dat_o <= '0;
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            wbm_rty_o <= 1'b0;
            wbs_adr_o <= '0;
            wbs_dat_o <= '0;
            wbs_sel_o <= '0;
            wbs_we_o  <= 1'b0;
            wbs_cyc_o <= '0;
            wbs_stb_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i) begin
                        if (hit_c) begin
                            wbs_adr_o <= wbm_adr_i;
                            wbs_dat_o <= wbm_dat_i;
                            wbs_sel_o <= SEL_WIDTH'(wbm_sel_i);
                            wbs_we_o  <= wbm_we_i;
                            sel_q     <= hit_onehot_c;
                            wbs_cyc_o <= hit_onehot_c;
                            wbs_stb_o <= hit_onehot_c;
                            cnt       <= '0;
                            state     <= ST_BUSY;
                        end else begin
                            wbm_err_o <= 1'b1;
                            state     <= ST_RESP;
                        end
                    end
                end

                ST_BUSY: begin
                    // Abort wins over any response arriving in the same cycle.
                    if (!wbm_cyc_i) begin
                        sel_q     <= '0;
                        wbs_cyc_o <= '0;
                        wbs_stb_o <= '0;
                        state     <= ST_IDLE;
                    end else if (rsp_c != RSP_NONE) begin
                        sel_q     <= '0;
                        wbs_cyc_o <= '0;
                        wbs_stb_o <= '0;
                        state     <= ST_RESP;
                        case (rsp_c)
                            RSP_ACK: begin
                                wbm_ack_o <= 1'b1;
                                wbm_dat_o <= rd_data_c;
                            end
                            RSP_ERR: wbm_err_o <= 1'b1;
                            RSP_RTY: wbm_rty_o <= 1'b1;
                            default: ;
                        endcase
                    end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                        sel_q     <= '0;
                        wbs_cyc_o <= '0;
                        wbs_stb_o <= '0;
                        wbm_err_o <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end

                ST_RESP: begin
                    wbm_ack_o <= 1'b0;
                    wbm_err_o <= 1'b0;
                    wbm_rty_o <= 1'b0;
                    state     <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_decoder.sv
// Self-checking bench for wb_decoder: directed scenarios plus a short random
// back-to-back run, with expected master responses queued as a scoreboard.
module tb_wb_decoder;

    logic          clk;
    logic          rst_n;
    logic [31:0]   wbm_adr_i;
    logic [31:0]   wbm_dat_i;
    logic [3:0]    wbm_sel_i;
    logic          wbm_we_i;
    logic          wbm_stb_i;
    logic          wbm_cyc_i;
    logic [31:0]   wbm_dat_o;
    logic          wbm_ack_o;
    logic          wbm_err_o;
    logic          wbm_rty_o;
    logic [31:0]   wbs_adr_o;
    logic [31:0]   wbs_dat_o;
    logic [3:0]    wbs_sel_o;
    logic          wbs_we_o;
    logic [3:0]    wbs_cyc_o;
    logic [3:0]    wbs_stb_o;
    logic [127:0]  wbs_dat_i;
    logic [3:0]    wbs_ack_i;
    logic [3:0]    wbs_err_i;
    logic [3:0]    wbs_rty_i;

    typedef struct {
        logic [2:0]  rsp;   // {ack, err, rty}
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks;
    int          errors;
    logic [31:0] last_dat;

    wb_decoder #(
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wbm_adr_i (wbm_adr_i),
        .wbm_dat_i (wbm_dat_i),
        .wbm_sel_i (wbm_sel_i),
        .wbm_we_i  (wbm_we_i),
        .wbm_stb_i (wbm_stb_i),
        .wbm_cyc_i (wbm_cyc_i),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_o (wbm_ack_o),
        .wbm_err_o (wbm_err_o),
        .wbm_rty_o (wbm_rty_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_i (wbs_ack_i),
        .wbs_err_i (wbs_err_i),
        .wbs_rty_i (wbs_rty_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic master_idle();
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        wbm_we_i  = 1'b0;
    endtask

    task automatic master_req(input logic [31:0] adr, input logic we, input logic [31:0] dat);
        wbm_adr_i = adr;
        wbm_we_i  = we;
        wbm_dat_i = dat;
        wbm_sel_i = 4'hF;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
    endtask

    task automatic slaves_quiet();
        wbs_ack_i = '0;
        wbs_err_i = '0;
        wbs_rty_i = '0;
    endtask

    task automatic push_exp(input logic [2:0] rsp, input logic [31:0] dat);
        exp_t e;
        e.rsp = rsp;
        e.dat = dat;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        master_idle();
        slaves_quiet();
        wbm_adr_i = '0;
        wbm_dat_i = '0;
        wbm_sel_i = '0;
        wbs_dat_i = '0;
        #12;
        checks++;
        if ({wbs_cyc_o, wbs_stb_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 00000000", {wbs_cyc_o, wbs_stb_o});
        end
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_rsp got %b exp 000", {wbm_ack_o, wbm_err_o, wbm_rty_o});
        end
        checks++;
        if (wbm_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_dat got %h exp 00000000", wbm_dat_o);
        end
        checks++;
        if ({wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o} !== 69'h0) begin
            errors++;
            $display("FAIL reset_bcast got adr=%h dat=%h sel=%b we=%b exp zero",
                     wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o);
        end
        last_dat = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_slave1();
        exp_t e;
        push_exp(3'b100, 32'hDEAD_BEEF);
        last_dat = 32'hDEAD_BEEF;
        master_req(32'h1000_0040, 1'b0, 32'h0);
        tick();
        checks++;
        if (wbs_stb_o !== 4'b0010 || wbs_cyc_o !== 4'b0010 || wbs_adr_o !== 32'h1000_0040) begin
            errors++;
            $display("FAIL read1_stb got stb=%b cyc=%b adr=%h exp 0010 0010 10000040",
                     wbs_stb_o, wbs_cyc_o, wbs_adr_o);
        end
        tick();
        wbs_dat_i = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
        wbs_ack_i = 4'b0010;
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== e.rsp || wbm_dat_o !== e.dat) begin
            errors++;
            $display("FAIL read1_rsp got rsp=%b dat=%h exp rsp=%b dat=%h",
                     {wbm_ack_o, wbm_err_o, wbm_rty_o}, wbm_dat_o, e.rsp, e.dat);
        end
        checks++;
        if (wbs_stb_o !== 4'b0000) begin
            errors++;
            $display("FAIL read1_stb_drop got %b exp 0000", wbs_stb_o);
        end
        slaves_quiet();
        master_idle();
        tick();
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b000 || wbm_dat_o !== last_dat) begin
            errors++;
            $display("FAIL read1_one_cycle got rsp=%b dat=%h exp rsp=000 dat=%h",
                     {wbm_ack_o, wbm_err_o, wbm_rty_o}, wbm_dat_o, last_dat);
        end
    endtask

    task automatic test_unmapped_write();
        exp_t e;
        push_exp(3'b010, last_dat);
        master_req(32'h4000_0000, 1'b1, 32'h1234_5678);
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== e.rsp || wbm_dat_o !== e.dat) begin
            errors++;
            $display("FAIL unmapped_rsp got rsp=%b dat=%h exp rsp=%b dat=%h",
                     {wbm_ack_o, wbm_err_o, wbm_rty_o}, wbm_dat_o, e.rsp, e.dat);
        end
        checks++;
        if ({wbs_cyc_o, wbs_stb_o} !== 8'h00) begin
            errors++;
            $display("FAIL unmapped_stb got %b exp 00000000", {wbs_cyc_o, wbs_stb_o});
        end
        master_idle();
        tick();
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b000) begin
            errors++;
            $display("FAIL unmapped_one_cycle got %b exp 000", {wbm_ack_o, wbm_err_o, wbm_rty_o});
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        push_exp(3'b010, last_dat);
        master_req(32'h2000_0010, 1'b0, 32'h0);
        tick();
        checks++;
        if (wbs_stb_o !== 4'b0100) begin
            errors++;
            $display("FAIL timeout_stb got %b exp 0100", wbs_stb_o);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (wbs_stb_o !== 4'b0100 || {wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b000) begin
                errors++;
                $display("FAIL timeout_busy_%0d got stb=%b rsp=%b exp 0100 000",
                         i, wbs_stb_o, {wbm_ack_o, wbm_err_o, wbm_rty_o});
            end
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== e.rsp || wbm_dat_o !== e.dat) begin
            errors++;
            $display("FAIL timeout_rsp got rsp=%b dat=%h exp rsp=%b dat=%h",
                     {wbm_ack_o, wbm_err_o, wbm_rty_o}, wbm_dat_o, e.rsp, e.dat);
        end
        checks++;
        if (wbs_stb_o !== 4'b0000 || wbs_cyc_o !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_drop got stb=%b cyc=%b exp 0000", wbs_stb_o, wbs_cyc_o);
        end
        master_idle();
        tick();
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_one_cycle got %b exp 000", {wbm_ack_o, wbm_err_o, wbm_rty_o});
        end
    endtask

    task automatic test_priority();
        exp_t e;
        push_exp(3'b010, last_dat);
        master_req(32'h0000_0100, 1'b0, 32'h0);
        tick();
        checks++;
        if (wbs_stb_o !== 4'b0001) begin
            errors++;
            $display("FAIL prio_stb got %b exp 0001", wbs_stb_o);
        end
        wbs_dat_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hBAD0_BAD0};
        wbs_ack_i = 4'b1001;
        wbs_err_i = 4'b0001;
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== e.rsp || wbm_dat_o !== e.dat) begin
            errors++;
            $display("FAIL prio_rsp got rsp=%b dat=%h exp rsp=%b dat=%h",
                     {wbm_ack_o, wbm_err_o, wbm_rty_o}, wbm_dat_o, e.rsp, e.dat);
        end
        slaves_quiet();
        master_idle();
        tick();
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b000 || wbs_stb_o !== 4'b0000) begin
            errors++;
            $display("FAIL prio_after got rsp=%b stb=%b exp 000 0000",
                     {wbm_ack_o, wbm_err_o, wbm_rty_o}, wbs_stb_o);
        end
    endtask

    task automatic test_ignore_nonselected();
        exp_t e;
        push_exp(3'b001, last_dat);
        master_req(32'h1000_0000, 1'b0, 32'h0);
        tick();
        wbs_ack_i = 4'b1101;
        wbs_err_i = 4'b0100;
        wbs_rty_i = 4'b1000;
        tick();
        checks++;
        if (wbs_stb_o !== 4'b0010 || {wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b000) begin
            errors++;
            $display("FAIL ignore_others got stb=%b rsp=%b exp 0010 000",
                     wbs_stb_o, {wbm_ack_o, wbm_err_o, wbm_rty_o});
        end
        wbs_ack_i = 4'b0010;
        wbs_err_i = 4'b0000;
        wbs_rty_i = 4'b0010;
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== e.rsp || wbm_dat_o !== e.dat) begin
            errors++;
            $display("FAIL rty_rsp got rsp=%b dat=%h exp rsp=%b dat=%h",
                     {wbm_ack_o, wbm_err_o, wbm_rty_o}, wbm_dat_o, e.rsp, e.dat);
        end
        slaves_quiet();
        master_idle();
        tick();
    endtask

    task automatic test_abort_and_reset();
        exp_t e;
        master_req(32'h3000_0000, 1'b0, 32'h0);
        tick();
        checks++;
        if (wbs_stb_o !== 4'b1000) begin
            errors++;
            $display("FAIL abort_stb got %b exp 1000", wbs_stb_o);
        end
        master_idle();
        tick();
        checks++;
        if ({wbs_cyc_o, wbs_stb_o} !== 8'h00 || {wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b000) begin
            errors++;
            $display("FAIL abort_drop got strobes=%b rsp=%b exp 0 000",
                     {wbs_cyc_o, wbs_stb_o}, {wbm_ack_o, wbm_err_o, wbm_rty_o});
        end
        tick();
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b000) begin
            errors++;
            $display("FAIL abort_no_rsp got %b exp 000", {wbm_ack_o, wbm_err_o, wbm_rty_o});
        end
        master_req(32'h0000_0000, 1'b0, 32'h0);
        tick();
        checks++;
        if (wbs_stb_o !== 4'b0001) begin
            errors++;
            $display("FAIL rst_pre_stb got %b exp 0001", wbs_stb_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wbs_cyc_o, wbs_stb_o} !== 8'h00 || wbm_dat_o !== 32'h0 ||
            {wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid got strobes=%b dat=%h rsp=%b exp 0 0 000",
                     {wbs_cyc_o, wbs_stb_o}, wbm_dat_o, {wbm_ack_o, wbm_err_o, wbm_rty_o});
        end
        last_dat = 32'h0;
        master_idle();
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if (wbs_stb_o !== 4'b0000 || {wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b000) begin
            errors++;
            $display("FAIL rst_release got stb=%b rsp=%b exp 0000 000",
                     wbs_stb_o, {wbm_ack_o, wbm_err_o, wbm_rty_o});
        end
        push_exp(3'b100, 32'hCAFE_F00D);
        last_dat = 32'hCAFE_F00D;
        master_req(32'h2000_0000, 1'b0, 32'h0);
        tick();
        checks++;
        if (wbs_stb_o !== 4'b0100) begin
            errors++;
            $display("FAIL rst_next_stb got %b exp 0100", wbs_stb_o);
        end
        wbs_dat_i = {32'h0, 32'hCAFE_F00D, 32'h0, 32'h0};
        wbs_ack_i = 4'b0100;
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== e.rsp || wbm_dat_o !== e.dat) begin
            errors++;
            $display("FAIL rst_next_rsp got rsp=%b dat=%h exp rsp=%b dat=%h",
                     {wbm_ack_o, wbm_err_o, wbm_rty_o}, wbm_dat_o, e.rsp, e.dat);
        end
        slaves_quiet();
        master_idle();
        tick();
    endtask

    // Generic access against the default map: top nibble 0..3 selects a slave.
    task automatic do_access(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                             input logic [31:0] rdat, input int dly);
        exp_t       e;
        int         port;
        logic [3:0] exp_sel;
        port    = (adr[31:28] < 4'd4) ? int'(adr[31:28]) : -1;
        exp_sel = (port >= 0) ? 4'(1 << port) : 4'b0000;
        if (port >= 0) begin
            push_exp(3'b100, rdat);
            last_dat = rdat;
        end else begin
            push_exp(3'b010, last_dat);
        end
        master_req(adr, we, wdat);
        tick();
        checks++;
        if (wbs_stb_o !== exp_sel) begin
            errors++;
            $display("FAIL b2b_stb adr=%h got %b exp %b", adr, wbs_stb_o, exp_sel);
        end
        if (port >= 0) begin
            checks++;
            if (wbs_adr_o !== adr || wbs_dat_o !== wdat || wbs_we_o !== we || wbs_sel_o !== 4'hF) begin
                errors++;
                $display("FAIL b2b_bcast got adr=%h dat=%h we=%b sel=%b exp %h %h %b 1111",
                         wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, adr, wdat, we);
            end
            repeat (dly) tick();
            wbs_dat_i = '0;
            wbs_dat_i[port*32 +: 32] = rdat;
            wbs_ack_i = exp_sel;
            tick();
            slaves_quiet();
        end
        e = exp_q.pop_front();
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== e.rsp || wbm_dat_o !== e.dat) begin
            errors++;
            $display("FAIL b2b_rsp adr=%h got rsp=%b dat=%h exp rsp=%b dat=%h",
                     adr, {wbm_ack_o, wbm_err_o, wbm_rty_o}, wbm_dat_o, e.rsp, e.dat);
        end
        master_idle();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  nib;
        logic [31:0] adr;
        do_access(32'h3FFF_FFFC, 1'b1, 32'hA5A5_0001, 32'h0BAD_F00D, 0);
        do_access(32'h5000_0000, 1'b0, 32'h0, 32'h0, 0);
        do_access(32'h0FFF_FFFF, 1'b0, 32'h0, 32'h1357_9BDF, 1);
        for (int i = 0; i < 8; i++) begin
            nib = 4'($urandom_range(0, 5));
            adr = {nib, 28'($urandom)};
            do_access(adr, 1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_read_slave1();
        test_unmapped_write();
        test_timeout();
        test_priority();
        test_ignore_nonselected();
        test_abort_and_reset();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
